// File: rtl/counter_arbiter_pkg.sv
// Shared types and helpers for the counter arbiter: FSM state encoding,
// the operation encoding and the per-requester operation decoder.
package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_t;

  // Decode one requester's three lines into a single operation.
  // Load wins over up, up wins over down.
  function automatic op_t get_op(input logic ld, input logic up, input logic dn);
    if (ld)      return OP_LOAD;
    else if (up) return OP_UP;
    else if (dn) return OP_DOWN;
    else         return OP_NONE;
  endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: starting just after the most recently
// granted index, returns the first requesting index (wrapping modulo N).
module round_robin_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_requesting,
  input  logic [IW-1:0] i_last,
  output logic          o_valid,
  output logic [IW-1:0] o_index
);

  logic [IW-1:0] w_idx;

  // Scan N positions starting at last+1; the first hit wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(i_last) + 1 + k) % N);
      if (!o_valid && i_requesting[w_idx]) begin
        o_valid = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shares one up/down counter among N requesters. Each transaction is one
// four-phase handshake on the requester side and one single-cycle strobe on
// the counter side; up/down additionally wait for the counter's ack.
//
// Handshake: requester i holds its request lines and reqData stable until
// reqAck[i] rises, then drops all lines; reqAck[i] stays high until every
// line of requester i is low, and falls on the following clock edge.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    reqUp,
  input  logic [N-1:0]    reqDown,
  input  logic [N-1:0]    reqLoad,
  input  logic [N*SIZE-1:0] reqData,
  output logic [N-1:0]    reqAck,
  output logic            up,
  output logic            down,
  output logic            load,
  output logic [SIZE-1:0] data,
  input  logic            upAck,
  input  logic            downAck,
  output logic            timeout,
  output logic            busy,
  output state_t          o_dbg_state
);

  localparam int IW  = $clog2(N);
  localparam int WCW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  state_t          r_state;
  op_t             r_op;
  logic [IW-1:0]   r_winner;
  logic [IW-1:0]   r_last;
  logic [SIZE-1:0] r_data;
  logic [WCW-1:0]  r_wait_cnt;
  logic [N-1:0]    r_req_ack;
  logic            r_up;
  logic            r_down;
  logic            r_load;
  logic            r_timeout;
  logic            r_busy;

  logic [N-1:0]    w_requesting;
  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_index;
  op_t             w_pick_op;
  logic [SIZE-1:0] w_pick_data;
  logic [N-1:0]    w_winner_onehot;
  logic [WCW-1:0]  w_wait_next;
  logic            w_ack_match;
  logic            w_wait_expired;
  logic            w_winner_idle;

  assign w_requesting = reqUp | reqDown | reqLoad;

  round_robin_picker #(.N(N)) u_picker (
    .i_requesting (w_requesting),
    .i_last       (r_last),
    .o_valid      (w_pick_valid),
    .o_index      (w_pick_index)
  );

  assign w_pick_op   = get_op(reqLoad[w_pick_index], reqUp[w_pick_index], reqDown[w_pick_index]);
  assign w_pick_data = reqData[w_pick_index*SIZE +: SIZE];

  // One-hot acknowledge vector for the latched winner.
  always_comb begin
    w_winner_onehot           = '0;
    w_winner_onehot[r_winner] = 1'b1;
  end

  // WAIT cycles are counted from 1; only the ack matching the issued
  // operation ends the wait, the other one is ignored.
  assign w_wait_next    = r_wait_cnt + WCW'(1);
  assign w_wait_expired = (w_wait_next == WCW'(TIMEOUT));
  assign w_ack_match    = ((r_op == OP_UP) && upAck) || ((r_op == OP_DOWN) && downAck);
  assign w_winner_idle  = !w_requesting[r_winner];

  // Transaction FSM with all outputs registered. Strobes are set on the
  // edge entering ISSUE and cleared on the edge leaving it, so each
  // transaction produces exactly one strobe cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NONE;
      r_winner   <= '0;
      r_last     <= IW'(N - 1);
      r_data     <= '0;
      r_wait_cnt <= '0;
      r_req_ack  <= '0;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_load     <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_winner <= w_pick_index;
            r_op     <= w_pick_op;
            r_data   <= w_pick_data;
            r_up     <= (w_pick_op == OP_UP);
            r_down   <= (w_pick_op == OP_DOWN);
            r_load   <= (w_pick_op == OP_LOAD);
            r_busy   <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_up       <= 1'b0;
          r_down     <= 1'b0;
          r_load     <= 1'b0;
          r_wait_cnt <= '0;
          if (r_op == OP_LOAD) begin
            r_req_ack <= w_winner_onehot;
            r_state   <= ST_ACK;
          end else begin
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_wait_cnt <= w_wait_next;
          if (w_ack_match) begin
            r_req_ack <= w_winner_onehot;
            r_state   <= ST_ACK;
          end else if (w_wait_expired) begin
            r_timeout <= 1'b1;
            r_req_ack <= w_winner_onehot;
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_last <= r_winner;
          if (w_winner_idle) begin
            r_req_ack <= '0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign reqAck      = r_req_ack;
  assign up          = r_up;
  assign down        = r_down;
  assign load        = r_load;
  assign data        = r_data;
  assign timeout     = r_timeout;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: a table of single transactions plus
// hand-written round-robin, timeout and mid-transaction reset sequences.
// A small behavioural up/down counter sits on the command side.
module tb_counter_arbiter;
  import counter_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int SIZE = 8;
  localparam int OPU  = 0;
  localparam int OPD  = 1;
  localparam int OPL  = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    reqUp;
  logic [N-1:0]    reqDown;
  logic [N-1:0]    reqLoad;
  logic [N*SIZE-1:0] reqData;
  logic [N-1:0]    reqAck;
  logic            up;
  logic            down;
  logic            load;
  logic [SIZE-1:0] data;
  logic            upAck;
  logic            downAck;
  logic            timeout;
  logic            busy;
  state_t          dbg_state;

  logic            ack_en;
  logic [SIZE-1:0] cnt;

  int n_checks;
  int n_fail;

  counter_arbiter #(.N(N), .SIZE(SIZE), .TIMEOUT(15)) dut (
    .clock       (clk),
    .reset       (reset),
    .reqUp       (reqUp),
    .reqDown     (reqDown),
    .reqLoad     (reqLoad),
    .reqData     (reqData),
    .reqAck      (reqAck),
    .up          (up),
    .down        (down),
    .load        (load),
    .data        (data),
    .upAck       (upAck),
    .downAck     (downAck),
    .timeout     (timeout),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural counter; ack_en=0 acts as a stub that never acks.
  always @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      upAck   <= 1'b0;
      downAck <= 1'b0;
    end else begin
      upAck   <= up & ack_en;
      downAck <= down & ack_en;
      if (load)      cnt <= data;
      else if (up)   cnt <= cnt + 8'd1;
      else if (down) cnt <= cnt - 8'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise one requester, watch strobes until its ack, then release it.
  task automatic run_txn(input int id, input logic u, input logic d, input logic l,
                         input logic [7:0] dat, input int exp_op, input int exp_lat,
                         output int to_cyc);
    int lat, n_up, n_dn, n_ld, s_cyc;
    logic [7:0] ld_data;
    logic [N-1:0] ack_vec, exp_vec;
    lat = 0; n_up = 0; n_dn = 0; n_ld = 0; s_cyc = 0; to_cyc = 0;
    ld_data = '0; ack_vec = '0;
    reqUp[id] = u; reqDown[id] = d; reqLoad[id] = l;
    reqData[id*SIZE +: SIZE] = dat;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (up)   begin n_up++; s_cyc = c; end
      if (down) begin n_dn++; s_cyc = c; end
      if (load) begin n_ld++; s_cyc = c; ld_data = data; end
      if (timeout && to_cyc == 0) to_cyc = c;
      if (reqAck != '0) begin lat = c; ack_vec = reqAck; break; end
    end
    exp_vec = '0;
    exp_vec[id] = 1'b1;
    check("ack_latency", lat, exp_lat);
    check("ack_onehot", 32'(ack_vec), 32'(exp_vec));
    check("up_pulses", n_up, (exp_op == OPU) ? 1 : 0);
    check("down_pulses", n_dn, (exp_op == OPD) ? 1 : 0);
    check("load_pulses", n_ld, (exp_op == OPL) ? 1 : 0);
    check("strobe_cycle", s_cyc, 1);
    if (exp_op == OPL) check("load_data", 32'(ld_data), 32'(dat));
    reqUp[id] = 1'b0; reqDown[id] = 1'b0; reqLoad[id] = 1'b0;
    @(negedge clk);
    check("ack_fall", 32'(reqAck), 32'h0);
    check("busy_after", 32'(busy), 32'h0);
  endtask

  // Wait for any acknowledge and report which requester got it.
  task automatic wait_ack(output int idx);
    idx = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (reqAck != '0) begin
        for (int i = 0; i < N; i++) if (reqAck[i]) idx = i;
        break;
      end
    end
    if (idx < 0) check("ack_wait_bound", 32'(reqAck != '0), 32'h1);
  endtask

  typedef struct {
    int         id;
    logic       u;
    logic       d;
    logic       l;
    logic [7:0] dat;
    int         exp_op;
    int         exp_lat;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];
  int   exp_order[4];

  initial begin
    int to_cyc, idx;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; reqUp = '0; reqDown = '0; reqLoad = '0; reqData = '0; ack_en = 1'b1;

    vecs[0] = '{0, 1'b1, 1'b0, 1'b0, 8'h00, OPU, 3, 8'h01};
    vecs[1] = '{2, 1'b1, 1'b0, 1'b1, 8'hA5, OPL, 2, 8'hA5};
    vecs[2] = '{3, 1'b0, 1'b1, 1'b0, 8'h00, OPD, 3, 8'hA4};
    vecs[3] = '{1, 1'b0, 1'b0, 1'b1, 8'hFF, OPL, 2, 8'hFF};
    vecs[4] = '{1, 1'b1, 1'b0, 1'b0, 8'h00, OPU, 3, 8'h00};
    vecs[5] = '{0, 1'b0, 1'b0, 1'b1, 8'h00, OPL, 2, 8'h00};
    vecs[6] = '{3, 1'b0, 1'b1, 1'b0, 8'h00, OPD, 3, 8'hFF};
    vecs[7] = '{2, 1'b1, 1'b1, 1'b0, 8'h00, OPU, 3, 8'h00};
    vecs[8] = '{1, 1'b0, 1'b1, 1'b1, 8'h3C, OPL, 2, 8'h3C};
    exp_order = '{0, 1, 3, 0};

    // Reset state
    do_reset();
    check("rst_reqAck", 32'(reqAck), 32'h0);
    check("rst_strobes", 32'({up, down, load}), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Table of single transactions
    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].id, vecs[v].u, vecs[v].d, vecs[v].l, vecs[v].dat,
              vecs[v].exp_op, vecs[v].exp_lat, to_cyc);
      check("count", 32'(cnt), 32'(vecs[v].exp_cnt));
      check("no_timeout", 32'(timeout), 32'h0);
    end

    // Round-robin among requesters 0, 1, 3 from reset
    do_reset();
    reqUp[0] = 1'b1; reqUp[1] = 1'b1; reqUp[3] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ack(idx);
      check("rr_grant", idx, exp_order[g]);
      if (idx >= 0) begin
        reqUp[idx] = 1'b0;
        @(negedge clk);
        check("rr_ack_fall", 32'(reqAck), 32'h0);
        if (g < 3) reqUp[idx] = 1'b1;
      end
    end
    reqUp = '0;
    repeat (2) @(negedge clk);
    check("rr_count", 32'(cnt), 32'h4);

    // Timeout: acks suppressed, 15 WAIT cycles then ack anyway
    do_reset();
    ack_en = 1'b0;
    run_txn(1, 1'b1, 1'b0, 1'b0, 8'h00, OPU, 17, to_cyc);
    check("timeout_cycle", to_cyc, 17);
    check("timeout_sticky", 32'(timeout), 32'h1);
    ack_en = 1'b1;
    run_txn(0, 1'b1, 1'b0, 1'b0, 8'h00, OPU, 3, to_cyc);
    check("timeout_still", 32'(timeout), 32'h1);
    do_reset();
    check("timeout_cleared", 32'(timeout), 32'h0);

    // Reset in the middle of WAIT
    ack_en = 1'b0;
    reqUp[2] = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_state", 32'(dbg_state), 32'(ST_WAIT));
    check("mid_busy", 32'(busy), 32'h1);
    reqUp[0] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", 32'({reqAck, up, down, load, timeout, busy}), 32'h0);
    check("mid_rst_data", 32'(data), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    ack_en = 1'b1;
    wait_ack(idx);
    check("mid_first_grant", idx, 0);
    reqUp[0] = 1'b0;
    @(negedge clk);
    wait_ack(idx);
    check("mid_second_grant", idx, 2);
    reqUp[2] = 1'b0;
    @(negedge clk);
    check("mid_count", 32'(cnt), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

- Shares one `UpDownCounter` instance among `N` requesters.
- Each requester issues a load, increment or decrement request over a four-phase handshake.
- The arbiter picks one requester round-robin, drives the counter's `up`/`down`/`load` strobes for exactly one cycle, waits for the counter's `upAck`/`downAck`, then acknowledges the requester.
- It sits directly between the requester blocks and the counter; all counter command inputs are driven only by this block.

## Interface

Parameters:

- `N`, 4, number of requesters (2..8)
- `SIZE`, 8, counter/data width; must match the counter instance
- `TIMEOUT`, 15, max cycles to wait for a counter ack before flagging an error

Ports:

- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `reqUp`  in  N  per-requester increment request
- `reqDown`  in  N  per-requester decrement request
- `reqLoad`  in  N  per-requester load request
- `reqData`  in  N*SIZE  load values; requester i owns bits [i*SIZE +: SIZE]
- `reqAck`  out  N  per-requester acknowledge, one-hot or zero
- `up`  out  1  counter increment strobe
- `down`  out  1  counter decrement strobe
- `load`  out  1  counter load strobe
- `data`  out  SIZE  counter load value
- `upAck`  in  1  counter increment acknowledge
- `downAck`  in  1  counter decrement acknowledge
- `timeout`  out  1  sticky error flag: an ack failed to arrive within TIMEOUT cycles
- `busy`  out  1  high whenever state is not IDLE

## Operation

- Requester i is "requesting" when any of `reqUp[i]`, `reqDown[i]`, `reqLoad[i]` is high.
- Operation priority within one requester: load > up > down. This is fixed at grant time and held for the transaction.
- Requesters hold request lines and `reqData` stable until `reqAck[i]` rises, then drop all request lines. `reqAck[i]` stays high until all of requester i's lines are low.
- Arbitration is round-robin. The search starts at `(last+1) mod N`, where `last` is the most recently granted index; after reset, `last` = N-1, so index 0 is searched first.
- States:
  - IDLE: if any requester is requesting, register winner index, operation and data, then go to ISSUE. Otherwise stay.
  - ISSUE: exactly one of `up`/`down`/`load` is high for this single cycle, with `data` = latched value. Load goes to ACK; up/down go to WAIT.
  - WAIT: all strobes low; a 4-bit-or-wider wait counter increments.
    - Matching ack (`upAck` for up, `downAck` for down) goes to ACK.
    - If the wait counter reaches TIMEOUT, set `timeout` and go to ACK.
    - A non-matching ack is ignored.
  - ACK: `reqAck[winner]` high; `last` <= winner. When requester winner has all lines low, go to IDLE.
- Strobes are never high outside ISSUE. A single-cycle strobe guarantees exactly one count step per transaction.
- `data` holds the last latched value outside ISSUE; it is don't-care when `load`=0.
- Reset from any state: outputs go to `up`=`down`=`load`=0, `reqAck`=0, `data`=0, `timeout`=0, `busy`=0; state IDLE; `last` = N-1; the in-flight transaction is discarded with no ack.

## Timing

- All outputs are registered.
- Up/down latency: request seen in IDLE at cycle T, then:
  - T+1: ISSUE, strobe high.
  - T+2: counter raises `upAck`/`downAck`; arbiter is in WAIT.
  - T+3: ACK, `reqAck` high.
- Load latency: request at T, ISSUE at T+1, `reqAck` at T+2.
- Minimum IDLE gap between transactions: one cycle after the requester drops its lines.
- Ack is sampled only in WAIT. TIMEOUT counts WAIT cycles starting at 1.

## Structure

- Package `counter_arbiter_pkg`:
  - state encoding IDLE/ISSUE/WAIT/ACK
  - op encoding OP_LOAD/OP_UP/OP_DOWN
  - a function returning the operation from a requester's three lines.
- Sub-module `round_robin_picker #(N)`: combinational inputs requesting vector and `last`; outputs `valid` and `index`. The FSM and latches remain in `counter_arbiter`.

## Test plan

- Single up: reset, requester 0 raises `reqUp`. `up` is high only at T+1, `reqAck[0]` at T+3; counter reads 1 after one transaction. Drop the request, then `reqAck[0]` falls next cycle.
- Round-robin: requesters 0, 1 and 3 all hold `reqUp`. Grants occur in order 0, 1, 3, 0; counter reads 4 after four transactions.
- Priority and load: requester 2 raises `reqLoad`+`reqUp` with data 8'hA5. Only `load` pulses with `data`=8'hA5 and no `up`; `reqAck[2]` at T+2; counter reads 8'hA5.
- Wrap-around: load 8'hFF, then requester 1 requests up, so the counter reads 8'h00. Then load 8'h00 and request down, so the counter reads 8'hFF; each transaction is acked once.
- Timeout: hold counter acks low via a stub. After up is issued, `timeout` rises after 15 WAIT cycles and `reqAck` still asserts; `timeout` stays high until reset.
- Reset mid-operation: assert `reset` during WAIT. Next cycle all outputs are 0 and state is IDLE; a pending request from requester 0 is then re-served from index 0.
